// File: rtl/jt12_lininterp.sv
// Linear-interpolation upsampler: ramps from the previous input sample to the current one in 2^LOG2R steps.
// Define JT12_LININTERP_ROUND_EN for round-half-up output with positive saturation; truncating shift otherwise.
module jt12_lininterp #(
  parameter int DW    = 16,
  parameter int LOG2R = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen_in,
  input  logic signed [DW-1:0] din,
  input  logic                 cen_out,
  output logic signed [DW-1:0] dout,
  output logic                 step_ovr,
  output logic                 early
);

  localparam int AW = DW + 1 + LOG2R;
  localparam logic [LOG2R-1:0] PHASE_MAX = '1;

  logic signed [DW-1:0]  prev;
  logic signed [DW-1:0]  cur;
  logic signed [DW:0]    delta;
  logic signed [AW-1:0]  acc;
  logic [LOG2R-1:0]      phase;

  logic signed [DW:0]    delta_next;
  logic signed [AW-1:0]  acc_load;
  logic signed [AW-1:0]  delta_ext;
  logic signed [DW-1:0]  dout_next;

  // One extra bit keeps din-cur exact across the full signed range.
  assign delta_next = {din[DW-1], din} - {cur[DW-1], cur};
  assign acc_load   = {cur[DW-1], cur, {LOG2R{1'b0}}};
  assign delta_ext  = {{LOG2R{delta[DW]}}, delta};

`ifdef JT12_LININTERP_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (LOG2R - 1));
  logic signed [AW-1:0] acc_rnd;
  logic signed [DW:0]   rnd_q;
  logic                 unused_bits;

  assign acc_rnd = acc + HALF;
  assign rnd_q   = acc_rnd[AW-1:LOG2R];

  // acc never drops below the negative endpoint, so only positive overflow can occur.
  always_comb begin
    dout_next = rnd_q[DW-1:0];
    if (!rnd_q[DW] && rnd_q[DW-1])
      dout_next = {1'b0, {(DW-1){1'b1}}};
  end

  assign unused_bits = ^{prev, acc_rnd[LOG2R-1:0]};
`else
  logic unused_bits;

  // acc stays between the two endpoints, so its top bit is redundant after the shift.
  assign dout_next   = acc[DW+LOG2R-1:LOG2R];
  assign unused_bits = ^{prev, acc[AW-1], acc[LOG2R-1:0]};
`endif

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      cur      <= '0;
      delta    <= '0;
      acc      <= '0;
      phase    <= '0;
      dout     <= '0;
      step_ovr <= 1'b0;
      early    <= 1'b0;
    end else begin
      dout  <= dout_next;
      early <= 1'b0;
      if (cen_in) begin
        // A new sample wins over a coincident output step; that step is dropped.
        prev  <= cur;
        cur   <= din;
        delta <= delta_next;
        acc   <= acc_load;
        phase <= '0;
        early <= (phase != PHASE_MAX);
      end else if (cen_out) begin
        if (phase != PHASE_MAX) begin
          acc   <= acc + delta_ext;
          phase <= phase + 1'b1;
        end else begin
          step_ovr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_lininterp.sv
// Self-checking bench for jt12_lininterp: arithmetic ramp model feeds a scoreboard queue of expected dout.
module tb_jt12_lininterp;
  localparam int DW    = 16;
  localparam int LOG2R = 4;
  localparam int R     = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cen_in;
  logic signed [DW-1:0] din;
  logic                 cen_out;
  logic signed [DW-1:0] dout;
  logic                 step_ovr;
  logic                 early;

  int errors = 0;
  int checks = 0;

  int    sb[$];
  int    m_prev, m_cur, m_k;
  int    m_ovr, m_early, exp_dout;
  string tname = "reset";

  always #5 clk = ~clk;

  jt12_lininterp #(.DW(DW), .LOG2R(LOG2R)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen_in   (cen_in),
    .din      (din),
    .cen_out  (cen_out),
    .dout     (dout),
    .step_ovr (step_ovr),
    .early    (early)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  // Expected output for the current ramp point: prev + k*(cur-prev)/R, floored (or rounded).
  function automatic int model_out();
    int a, v;
    a = m_prev * R + m_k * (m_cur - m_prev);
`ifdef JT12_LININTERP_ROUND_EN
    v = fdiv(a + R / 2, R);
    if (v > 32767) v = 32767;
`else
    v = fdiv(a, R);
`endif
    return v;
  endfunction

  // Called at a negedge: drive inputs, update the model at posedge, compare at the next negedge.
  task automatic cyc(input bit ci, input int d, input bit co);
    cen_in  = ci;
    din     = d[DW-1:0];
    cen_out = co;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_prev = 0; m_cur = 0; m_k = 0; m_ovr = 0; m_early = 0;
      exp_dout = 0;
      sb.push_back(0);
    end else begin
      exp_dout = (sb.size() > 0) ? sb.pop_front() : 0;
      if (ci) begin
        m_early = (m_k != R - 1) ? 1 : 0;
        m_prev  = m_cur;
        m_cur   = d;
        m_k     = 0;
      end else begin
        m_early = 0;
        if (co) begin
          if (m_k < R - 1) m_k++;
          else m_ovr = 1;
        end
      end
      sb.push_back(model_out());
    end
    @(negedge clk);
    check({tname, ".dout"}, int'(dout), exp_dout);
    check({tname, ".early"}, int'(early), m_early);
    check({tname, ".step_ovr"}, int'(step_ovr), m_ovr);
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0);
  endtask

  initial begin
    int last;
    rst = 1'b1; cen_in = 1'b0; cen_out = 1'b0; din = '0;
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    rst = 1'b0;
    idle(2);
    check("reset.dout0", int'(dout), 0);

    tname = "ramp";
    cyc(1'b1, 0, 1'b0);
    steps(15);
    cyc(1'b1, 160, 1'b0);
    steps(15);
    idle(2);
    check("ramp.end150", int'(dout), 150);
    cyc(1'b1, 160, 1'b0);
    steps(15);
    idle(2);
    check("ramp.flat160", int'(dout), 160);

    tname = "neg";
    cyc(1'b1, 0, 1'b0);
    steps(15);
    cyc(1'b1, -16, 1'b0);
    steps(15);
    idle(2);
    check("neg.end", int'(dout), -15);
    cyc(1'b1, 0, 1'b0);
    steps(15);
    cyc(1'b1, -1, 1'b0);
    steps(1);
    idle(2);
`ifdef JT12_LININTERP_ROUND_EN
    check("neg.acc_m1", int'(dout), 0);
`else
    check("neg.acc_m1", int'(dout), -1);
`endif
    steps(14);

    tname = "ovr";
    cyc(1'b1, 48, 1'b0);
    steps(15);
    check("ovr.before", int'(step_ovr), 0);
    steps(1);
    check("ovr.rise", int'(step_ovr), 1);
    steps(4);
    idle(2);
`ifdef JT12_LININTERP_ROUND_EN
    check("ovr.hold", int'(dout), 45);
`else
    check("ovr.hold", int'(dout), 44);
`endif
    check("ovr.sticky", int'(step_ovr), 1);

    tname = "early";
    cyc(1'b1, 100, 1'b0);
    steps(5);
    cyc(1'b1, 200, 1'b0);
    check("early.pulse", int'(early), 1);
    idle(1);
    check("early.clear", int'(early), 0);
    check("early.restart", int'(dout), 100);
    steps(3);
    cyc(1'b1, 300, 1'b1);
    idle(2);
    check("simul.nostep", int'(dout), 200);

    tname = "ext";
    cyc(1'b1, -32768, 1'b0);
    steps(15);
    cyc(1'b1, -32768, 1'b0);
    steps(15);
    cyc(1'b1, 32767, 1'b0);
    idle(2);
    last = int'(dout);
    check("ext.start", last, -32768);
    for (int i = 0; i < 15; i++) begin
      steps(1);
      check("ext.mono", int'(int'(dout) >= last), 1);
      last = int'(dout);
    end
    idle(2);
    check("ext.top", int'(dout), 28671);
    cyc(1'b1, -32768, 1'b0);
    steps(15);
    idle(2);
`ifdef JT12_LININTERP_ROUND_EN
    check("ext.bottom", int'(dout), -28672);
`else
    check("ext.bottom", int'(dout), -28673);
`endif
    cyc(1'b1, 32767, 1'b0);
    steps(15);
    cyc(1'b1, 32767, 1'b0);
    steps(15);
    idle(2);
    check("ext.max", int'(dout), 32767);

    tname = "rstmid";
    cyc(1'b1, 0, 1'b0);
    steps(7);
    rst = 1'b1;
    cyc(1'b0, 0, 1'b0);
    rst = 1'b0;
    check("rstmid.dout", int'(dout), 0);
    check("rstmid.ovr", int'(step_ovr), 0);
    check("rstmid.early", int'(early), 0);
    cyc(1'b1, 32, 1'b0);
    steps(15);
    idle(2);
    check("rstmid.ramp", int'(dout), 30);
    cyc(1'b1, 32, 1'b0);
    steps(15);
    idle(2);
    check("rstmid.flat", int'(dout), 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
